// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter
//  Purpose  : Round-robin arbiter sharing the single regfile write port among
//             N_REQ completing units; winner is registered onto the port.
//  Revision : 1.0
// ============================================================================
module rf_wb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      rf_wena,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [2:0]                last_grant,
    output logic [31:0]               wr_count
);

    localparam int               PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]   c_n   = (PTR_W+1)'(N_REQ);

    logic [PTR_W-1:0]  r_rr_ptr;
    logic              r_wena;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_last_grant;
    logic [31:0]       r_wr_count;

    logic [PTR_W:0]    w_tmp;
    logic [PTR_W-1:0]  w_dist [N_REQ];
    logic [N_REQ-1:0]  w_grant;
    logic [PTR_W-1:0]  w_gidx;
    logic [ADDR_W-1:0] w_gaddr;
    logic [DATA_W-1:0] w_gdata;
    logic              w_xfer;
    logic [PTR_W-1:0]  w_next_ptr;

    // Priority is the distance of each requester from the round-robin pointer;
    // the valid requester with the smallest distance wins.
    always_comb begin
        w_tmp   = '0;
        w_grant = '0;
        w_gidx  = '0;
        w_gaddr = '0;
        w_gdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_tmp = {1'b0, PTR_W'(i)} + c_n - {1'b0, r_rr_ptr};
            if (w_tmp >= c_n) begin
                w_tmp = w_tmp - c_n;
            end
            w_dist[i] = w_tmp[PTR_W-1:0];
        end
        for (int i = 0; i < N_REQ; i++) begin
            w_grant[i] = req_valid[i];
            for (int j = 0; j < N_REQ; j++) begin
                if (j != i && req_valid[j] && (w_dist[j] < w_dist[i])) begin
                    w_grant[i] = 1'b0;
                end
            end
        end
        if (rst || flush) begin
            w_grant = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            w_gidx  = w_gidx  | (PTR_W'(i) & {PTR_W{w_grant[i]}});
            w_gaddr = w_gaddr | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_grant[i]}});
            w_gdata = w_gdata | (req_data[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
        end
    end

    assign w_xfer     = |w_grant;
    assign w_next_ptr = (w_gidx == PTR_W'(N_REQ-1)) ? '0 : w_gidx + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_wena       <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_last_grant <= '0;
            r_wr_count   <= '0;
        end else begin
            // r0 writes are accepted but never reach the regfile or the counter
            r_wena <= w_xfer && (w_gaddr != '0);
            if (w_xfer) begin
                r_rr_ptr     <= w_next_ptr;
                r_last_grant <= 3'(w_gidx);
                r_waddr      <= w_gaddr;
                r_wdata      <= w_gdata;
                if (w_gaddr != '0) begin
                    r_wr_count <= r_wr_count + 32'd1;
                end
            end
        end
    end

    assign req_ready  = w_grant;
    assign rf_wena    = r_wena;
    assign rf_waddr   = r_waddr;
    assign rf_wdata   = r_wdata;
    assign last_grant = r_last_grant;
    assign wr_count   = r_wr_count;

endmodule
`default_nettype wire
